dcache_flush_ctrl: RTL and testbench

- Sequencer and arbiter for the per-index dirty-bit table (CACHE_DEPTH x 1, registered read, one shared index port).
- Normal operation: core-side accesses pass straight through to the table.
- On a flush request it takes ownership of the table and walks every index. For each dirty line it issues a write-back request, waits for the acknowledge, then clears that dirty bit.
- Sits between the cache control FSM, the dirty table and the write-back unit.

---
 rtl/dcache_flush_ctrl_pkg.sv | 18 +
 rtl/dcache_flush_ctrl.sv | 125 ++++++++++++
 tb/tb_dcache_flush_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_flush_ctrl_pkg.sv
// Shared sizing and state encoding for the dirty-table flush sequencer.
package dcache_flush_ctrl_pkg;

  // Index width and depth; must match the dirty table instantiated by the parent.
  localparam int unsigned DCACHE_INDEX_AW = 8;
  localparam int unsigned DCACHE_DEPTH    = 256;

  // Flush sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CHK  = 3'd2,
    ST_WB   = 3'd3,
    ST_CLR  = 3'd4,
    ST_DONE = 3'd5
  } flush_state_e;

endpackage

// File: rtl/dcache_flush_ctrl.sv
// Dirty-table arbiter and flush sequencer: passes core accesses through when
// idle, and on a flush walks every index, writing back and clearing dirty lines.
module dcache_flush_ctrl
  import dcache_flush_ctrl_pkg::*;
#(
  parameter int unsigned CACHE_INDEX_AW = DCACHE_INDEX_AW,
  parameter int unsigned CACHE_DEPTH    = DCACHE_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_req_i,
  output logic                      flush_done_o,
  output logic                      busy_o,
  input  logic [CACHE_INDEX_AW-1:0] core_index_i,
  input  logic                      core_wr_en_i,
  input  logic                      core_wr_dirty_i,
  output logic                      core_rd_dirty_o,
  output logic [CACHE_INDEX_AW-1:0] tbl_index_o,
  output logic                      tbl_wr_en_o,
  output logic                      tbl_wr_dirty_o,
  input  logic                      tbl_rd_dirty_i,
  output logic                      wb_req_o,
  output logic [CACHE_INDEX_AW-1:0] wb_index_o,
  input  logic                      wb_ack_i
);

  localparam logic [CACHE_INDEX_AW-1:0] LAST_IDX = CACHE_INDEX_AW'(CACHE_DEPTH - 1);
  localparam logic [CACHE_INDEX_AW-1:0] IDX_ONE  = CACHE_INDEX_AW'(1);

  flush_state_e                r_state;
  logic [CACHE_INDEX_AW-1:0]   r_idx;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_wb_req;
  logic [CACHE_INDEX_AW-1:0]   r_wb_index;

  flush_state_e                w_next_state;
  logic [CACHE_INDEX_AW-1:0]   w_next_idx;
  logic                        w_last;

  assign w_last = (r_idx == LAST_IDX);

  // Next-state and index-counter logic for the flush walk.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (flush_req_i) begin
          w_next_state = ST_RD;
          w_next_idx   = '0;
        end
      end
      ST_RD:   w_next_state = ST_CHK;
      ST_CHK: begin
        if (tbl_rd_dirty_i) begin
          w_next_state = ST_WB;
        end else if (w_last) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_RD;
          w_next_idx   = r_idx + IDX_ONE;
        end
      end
      ST_WB: begin
        if (wb_ack_i) begin
          w_next_state = ST_CLR;
        end
      end
      ST_CLR: begin
        if (w_last) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_RD;
          w_next_idx   = r_idx + IDX_ONE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, index and registered Moore outputs (decoded from the next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wb_req   <= 1'b0;
      r_wb_index <= '0;
    end else begin
      r_state  <= w_next_state;
      r_idx    <= w_next_idx;
      r_busy   <= (w_next_state != ST_IDLE);
      r_done   <= (w_next_state == ST_DONE);
      r_wb_req <= (w_next_state == ST_WB);
      if (w_next_state == ST_WB) begin
        r_wb_index <= w_next_idx;
      end
    end
  end

  assign busy_o       = r_busy;
  assign flush_done_o = r_done;
  assign wb_req_o     = r_wb_req;
  assign wb_index_o   = r_wb_index;

  // Table port mux: core owns the table only in IDLE; core writes are dropped otherwise.
  always_comb begin
    tbl_index_o    = r_idx;
    tbl_wr_en_o    = 1'b0;
    tbl_wr_dirty_o = 1'b0;
    if (r_state == ST_IDLE) begin
      tbl_index_o    = core_index_i;
      tbl_wr_en_o    = core_wr_en_i;
      tbl_wr_dirty_o = core_wr_dirty_i;
    end else if (r_state == ST_CLR) begin
      tbl_wr_en_o    = 1'b1;
    end
  end

  assign core_rd_dirty_o = tbl_rd_dirty_i;

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Directed bench for dcache_flush_ctrl with a small registered-read dirty table model.
module tb_dcache_flush_ctrl;

  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_req_i;
  logic          flush_done_o;
  logic          busy_o;
  logic [AW-1:0] core_index_i;
  logic          core_wr_en_i;
  logic          core_wr_dirty_i;
  logic          core_rd_dirty_o;
  logic [AW-1:0] tbl_index_o;
  logic          tbl_wr_en_o;
  logic          tbl_wr_dirty_o;
  logic          tbl_rd_dirty_i;
  logic          wb_req_o;
  logic [AW-1:0] wb_index_o;
  logic          wb_ack_i;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] wb_q[$];
  logic          mem [DEPTH];

  always #5 clk = ~clk;

  // Dirty table model: write-through storage, registered read of the old value.
  always_ff @(posedge clk) begin
    if (tbl_wr_en_o) mem[tbl_index_o] <= tbl_wr_dirty_o;
    tbl_rd_dirty_i <= mem[tbl_index_o];
  end

  dcache_flush_ctrl #(.CACHE_INDEX_AW(AW), .CACHE_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_req_i     (flush_req_i),
    .flush_done_o    (flush_done_o),
    .busy_o          (busy_o),
    .core_index_i    (core_index_i),
    .core_wr_en_i    (core_wr_en_i),
    .core_wr_dirty_i (core_wr_dirty_i),
    .core_rd_dirty_o (core_rd_dirty_o),
    .tbl_index_o     (tbl_index_o),
    .tbl_wr_en_o     (tbl_wr_en_o),
    .tbl_wr_dirty_o  (tbl_wr_dirty_o),
    .tbl_rd_dirty_i  (tbl_rd_dirty_i),
    .wb_req_o        (wb_req_o),
    .wb_index_o      (wb_index_o),
    .wb_ack_i        (wb_ack_i)
  );

  task automatic core_write(input logic [AW-1:0] idx, input logic val);
    @(negedge clk);
    core_index_i    = idx;
    core_wr_en_i    = 1'b1;
    core_wr_dirty_i = val;
    @(negedge clk);
    core_wr_en_i    = 1'b0;
    core_wr_dirty_i = 1'b0;
  endtask

  task automatic core_read(input logic [AW-1:0] idx, output logic val);
    @(negedge clk);
    core_index_i = idx;
    @(negedge clk);
    val = core_rd_dirty_o;
  endtask

  task automatic clear_table();
    for (int i = 0; i < DEPTH; i++) core_write(AW'(i), 1'b0);
  endtask

  // Runs one flush; acks each request on its (ack_delay+1)-th WB cycle.
  task automatic run_flush(input int ack_delay, input bit inject_wr,
                           output int done_cycle, output int busy_cycles,
                           output int done_pulses, output int stab_err,
                           output int wb_cycles, output logic idle_after);
    int wb_cnt;
    wb_q.delete();
    done_cycle = -1; busy_cycles = 0; done_pulses = 0;
    stab_err = 0; wb_cycles = 0; wb_cnt = 0;
    @(negedge clk);
    flush_req_i = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        flush_req_i = 1'b0;
        if (inject_wr) begin
          core_index_i    = AW'(4);
          core_wr_en_i    = 1'b1;
          core_wr_dirty_i = 1'b1;
        end
      end
      if (busy_o) busy_cycles++;
      if (wb_req_o) begin
        wb_cycles++;
        if (wb_cnt == 0) wb_q.push_back(wb_index_o);
        else if (wb_index_o !== wb_q[$]) stab_err++;
        wb_ack_i = (wb_cnt == ack_delay);
        wb_cnt++;
      end else begin
        wb_cnt   = 0;
        wb_ack_i = 1'b0;
      end
      if (flush_done_o) begin
        done_pulses++;
        done_cycle = cyc;
        break;
      end
    end
    core_wr_en_i    = 1'b0;
    core_wr_dirty_i = 1'b0;
    wb_ack_i        = 1'b0;
    @(negedge clk);
    idle_after = !busy_o;
    if (flush_done_o) done_pulses++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_o, flush_done_o, wb_req_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl busy/done/req=%b expected 000", {busy_o, flush_done_o, wb_req_o});
    end
    checks++;
    if (wb_index_o !== '0) begin
      failures++;
      $display("FAIL reset_wb_index got %0d expected 0", wb_index_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    logic v;
    @(negedge clk);
    core_index_i = AW'(5); core_wr_en_i = 1'b1; core_wr_dirty_i = 1'b1;
    #1;
    checks++;
    if ({tbl_wr_en_o, tbl_wr_dirty_o, tbl_index_o} !== {1'b1, 1'b1, AW'(5)}) begin
      failures++;
      $display("FAIL pt_write tbl en/dirty/index=%b/%b/%0d expected 1/1/5",
               tbl_wr_en_o, tbl_wr_dirty_o, tbl_index_o);
    end
    @(negedge clk);
    core_wr_en_i = 1'b0; core_wr_dirty_i = 1'b0;
    @(negedge clk);
    v = core_rd_dirty_o;
    checks++;
    if (v !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL pt_read rd=%b busy=%b expected rd=1 busy=0", v, busy_o);
    end
  endtask

  task automatic test_clean_flush();
    int dc, bc, dp, se, wc; logic ia;
    clear_table();
    run_flush(0, 1'b0, dc, bc, dp, se, wc, ia);
    checks++;
    if (dc !== 17) begin failures++; $display("FAIL clean_done_cycle got %0d expected 17", dc); end
    checks++;
    if (bc !== 17) begin failures++; $display("FAIL clean_busy_cycles got %0d expected 17", bc); end
    checks++;
    if (wb_q.size() !== 0 || wc !== 0) begin
      failures++; $display("FAIL clean_no_wb reqs=%0d cycles=%0d expected 0", wb_q.size(), wc);
    end
    checks++;
    if (dp !== 1 || ia !== 1'b1) begin
      failures++; $display("FAIL clean_done_once pulses=%0d idle_after=%b expected 1/1", dp, ia);
    end
  endtask

  task automatic test_multi_dirty();
    int dc, bc, dp, se, wc; logic ia; logic v;
    logic [AW-1:0] exp_idx [3];
    exp_idx[0] = AW'(0); exp_idx[1] = AW'(3); exp_idx[2] = AW'(7);
    clear_table();
    for (int i = 0; i < 3; i++) core_write(exp_idx[i], 1'b1);
    run_flush(3, 1'b0, dc, bc, dp, se, wc, ia);
    checks++;
    if (wb_q.size() !== 3) begin
      failures++; $display("FAIL multi_wb_count got %0d expected 3", wb_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wb_q[i] !== exp_idx[i]) begin
          failures++; $display("FAIL multi_wb_order[%0d] got %0d expected %0d", i, wb_q[i], exp_idx[i]);
        end
      end
    end
    checks++;
    if (se !== 0 || wc !== 12) begin
      failures++; $display("FAIL multi_wb_stable unstable=%0d wb_cycles=%0d expected 0/12", se, wc);
    end
    checks++;
    if (dc !== 32) begin failures++; $display("FAIL multi_done_cycle got %0d expected 32", dc); end
    for (int i = 0; i < 3; i++) begin
      core_read(exp_idx[i], v);
      checks++;
      if (v !== 1'b0) begin
        failures++; $display("FAIL multi_cleared idx %0d got %b expected 0", exp_idx[i], v);
      end
    end
  endtask

  task automatic test_ack_same_cycle();
    int dc, bc, dp, se, wc; logic ia; logic v;
    clear_table();
    core_write(AW'(2), 1'b1);
    run_flush(0, 1'b0, dc, bc, dp, se, wc, ia);
    checks++;
    if (wc !== 1 || wb_q.size() !== 1) begin
      failures++; $display("FAIL ack0_wb wb_cycles=%0d reqs=%0d expected 1/1", wc, wb_q.size());
    end else begin
      checks++;
      if (wb_q[0] !== AW'(2)) begin
        failures++; $display("FAIL ack0_wb_index got %0d expected 2", wb_q[0]);
      end
    end
    checks++;
    if (dc !== 19) begin failures++; $display("FAIL ack0_done_cycle got %0d expected 19", dc); end
    core_read(AW'(2), v);
    checks++;
    if (v !== 1'b0) begin failures++; $display("FAIL ack0_cleared got %b expected 0", v); end
  endtask

  task automatic test_core_wr_blocked();
    int dc, bc, dp, se, wc; logic ia; logic v;
    clear_table();
    run_flush(0, 1'b1, dc, bc, dp, se, wc, ia);
    checks++;
    if (dc !== 17 || wb_q.size() !== 0) begin
      failures++; $display("FAIL blocked_flush done_cycle=%0d reqs=%0d expected 17/0", dc, wb_q.size());
    end
    core_read(AW'(4), v);
    checks++;
    if (v !== 1'b0) begin failures++; $display("FAIL blocked_write idx4 got %b expected 0", v); end
  endtask

  task automatic test_reset_mid_flush();
    bit seen; int pulses; logic v;
    clear_table();
    core_write(AW'(3), 1'b1);
    seen = 1'b0; pulses = 0;
    wb_ack_i = 1'b0;
    @(negedge clk);
    flush_req_i = 1'b1;
    @(negedge clk);
    flush_req_i = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (wb_req_o) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen || wb_index_o !== AW'(3)) begin
      failures++; $display("FAIL rstmid_wb_pending seen=%0d index=%0d expected 1/3", seen, wb_index_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({wb_req_o, busy_o, flush_done_o} !== 3'b000) begin
      failures++; $display("FAIL rstmid_abort req/busy/done=%b expected 000", {wb_req_o, busy_o, flush_done_o});
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (flush_done_o) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL rstmid_no_done pulses=%0d expected 0", pulses); end
    core_read(AW'(3), v);
    checks++;
    if (v !== 1'b1) begin failures++; $display("FAIL rstmid_dirty_kept idx3 got %b expected 1", v); end
  endtask

  initial begin
    rst = 1'b1; flush_req_i = 1'b0; core_index_i = '0;
    core_wr_en_i = 1'b0; core_wr_dirty_i = 1'b0; wb_ack_i = 1'b0;
    test_reset();
    clear_table();
    test_passthrough();
    test_clean_flush();
    test_multi_dirty();
    test_ack_same_cycle();
    test_core_wr_blocked();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
